// File: rtl/sdr_init_refresh_seq.sv
// SDRAM power-up init sequencer (CKE hold, PRECHARGE ALL, 2x AUTO REFRESH, LMR)
// followed by periodic AUTO REFRESH scheduling with a req/gnt bus handshake.
module sdr_init_refresh_seq #(
  parameter int unsigned INIT_WAIT  = 10000,
  parameter int unsigned TRP        = 2,
  parameter int unsigned TRFC       = 7,
  parameter int unsigned TMRD       = 2,
  parameter int unsigned REF_PERIOD = 780,
  parameter logic [12:0] MODE_REG   = 13'h033,
  parameter int unsigned REF_MAX    = 8
) (
  input  logic        sdram_clk,
  input  logic        sdram_reset,
  input  logic        ref_gnt,
  output logic        init_done,
  output logic        ref_req,
  output logic [3:0]  ref_debt,
  output logic        ref_ovf,
  output logic        cmd_own,
  output logic        cmd_cke,
  output logic        cmd_cs_n,
  output logic        cmd_ras_n,
  output logic        cmd_cas_n,
  output logic        cmd_we_n,
  output logic [12:0] cmd_addr,
  output logic [1:0]  cmd_ba
);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_TRP, S_INIT_REF1, S_INIT_TRFC1,
    S_INIT_REF2, S_INIT_TRFC2, S_INIT_LMR, S_INIT_TMRD, S_IDLE,
    S_REF_WAIT_GNT, S_REF_PRE, S_REF_TRP, S_REF_CMD, S_REF_TRFC
  } state_t;

  localparam logic [15:0] WAIT_END = 16'(INIT_WAIT);
  localparam logic [15:0] TRP_END  = 16'(TRP - 1);
  localparam logic [15:0] TRFC_END = 16'(TRFC - 1);
  localparam logic [15:0] TMRD_END = 16'(TMRD - 1);
  localparam logic [15:0] IVL_END  = 16'(REF_PERIOD - 1);
  localparam logic [3:0]  DEBT_MAX = 4'(REF_MAX);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_DES = 4'b1111;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] ivl_q, ivl_d;
  logic [3:0]  debt_q, debt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        cke_q, cke_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic        own_q, own_d;
  logic        req_q, req_d;
  logic        expire;
  logic        drain;

  always_ff @(posedge sdram_clk) begin
    if (sdram_reset) begin
      state_q <= S_INIT_WAIT;
      cnt_q   <= '0;
      ivl_q   <= '0;
      debt_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_DES;
      addr_q  <= '0;
      ba_q    <= '0;
      own_q   <= 1'b1;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ivl_q   <= ivl_d;
      debt_q  <= debt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      own_q   <= own_d;
      req_q   <= req_d;
    end
  end

  // The reset state stands for the cycle before cycle 0, so during INIT_WAIT
  // cnt_q equals the current cycle index plus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    ivl_d   = ivl_q;
    debt_d  = debt_q;
    ovf_d   = ovf_q;
    expire  = 1'b0;

    if (done_q) begin
      if (ivl_q == IVL_END) begin
        ivl_d  = '0;
        expire = 1'b1;
      end else begin
        ivl_d = ivl_q + 16'd1;
      end
    end

    drain = (state_q == S_REF_TRFC) && (cnt_q == TRFC_END);

    if (expire && (debt_q == DEBT_MAX)) ovf_d = 1'b1;
    if (expire && !drain && (debt_q != DEBT_MAX)) debt_d = debt_q + 4'd1;
    else if (drain && !expire)                    debt_d = debt_q - 4'd1;

    case (state_q)
      S_INIT_WAIT:    if (cnt_q == WAIT_END) state_d = S_INIT_PRE;
      S_INIT_PRE:     begin state_d = S_INIT_TRP;   cnt_d = 16'd1; end
      S_INIT_TRP:     if (cnt_q == TRP_END)  state_d = S_INIT_REF1;
      S_INIT_REF1:    begin state_d = S_INIT_TRFC1; cnt_d = 16'd1; end
      S_INIT_TRFC1:   if (cnt_q == TRFC_END) state_d = S_INIT_REF2;
      S_INIT_REF2:    begin state_d = S_INIT_TRFC2; cnt_d = 16'd1; end
      S_INIT_TRFC2:   if (cnt_q == TRFC_END) state_d = S_INIT_LMR;
      S_INIT_LMR:     begin state_d = S_INIT_TMRD;  cnt_d = 16'd1; end
      S_INIT_TMRD:    if (cnt_q == TMRD_END) state_d = S_IDLE;
      S_IDLE:         if (debt_q != 4'd0)    state_d = S_REF_WAIT_GNT;
      S_REF_WAIT_GNT: if (ref_gnt)           state_d = S_REF_PRE;
      S_REF_PRE:      begin state_d = S_REF_TRP;    cnt_d = 16'd1; end
      S_REF_TRP:      if (cnt_q == TRP_END)  state_d = S_REF_CMD;
      S_REF_CMD:      begin state_d = S_REF_TRFC;   cnt_d = 16'd1; end
      S_REF_TRFC: begin
        // Gnt is only looked at here, so a dropped grant mid-tRFC is ignored.
        if (drain) begin
          if ((debt_d != 4'd0) && ref_gnt) state_d = S_REF_CMD;
          else                             state_d = S_IDLE;
        end
      end
      default:        state_d = S_INIT_WAIT;
    endcase

    done_d = done_q || (state_d == S_IDLE);
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    cke_d  = (state_d != S_INIT_WAIT);
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    own_d  = !((state_d == S_IDLE) || (state_d == S_REF_WAIT_GNT));
    req_d  = (state_d == S_REF_WAIT_GNT) || (state_d == S_REF_PRE) ||
             (state_d == S_REF_TRP) || (state_d == S_REF_CMD) ||
             (state_d == S_REF_TRFC);
    case (state_d)
      S_INIT_PRE, S_REF_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = 13'h0400;
      end
      S_INIT_REF1, S_INIT_REF2, S_REF_CMD: cmd_d = CMD_REF;
      S_INIT_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      default: ;
    endcase
  end

  assign init_done = done_q;
  assign ref_req   = req_q;
  assign ref_debt  = debt_q;
  assign ref_ovf   = ovf_q;
  assign cmd_own   = own_q;
  assign cmd_cke   = cke_q;
  assign cmd_cs_n  = cmd_q[3];
  assign cmd_ras_n = cmd_q[2];
  assign cmd_cas_n = cmd_q[1];
  assign cmd_we_n  = cmd_q[0];
  assign cmd_addr  = addr_q;
  assign cmd_ba    = ba_q;

endmodule

// File: tb/tb_sdr_init_refresh_seq.sv
// Directed bench for sdr_init_refresh_seq: init timing, single and back-to-back
// refresh, debt saturation, and reset in the middle of a refresh.
module tb_sdr_init_refresh_seq;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_DES = 4'b1111;

  logic        sdram_clk = 1'b0;
  logic        sdram_reset = 1'b1;
  logic        ref_gnt = 1'b0;
  logic        init_done, ref_req, ref_ovf, cmd_own;
  logic [3:0]  ref_debt;
  logic        cmd_cke, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n;
  logic [12:0] cmd_addr;
  logic [1:0]  cmd_ba;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  sdr_init_refresh_seq #(
    .INIT_WAIT(20), .TRP(2), .TRFC(7), .TMRD(2),
    .REF_PERIOD(50), .MODE_REG(13'h033), .REF_MAX(8)
  ) dut (
    .sdram_clk(sdram_clk), .sdram_reset(sdram_reset), .ref_gnt(ref_gnt),
    .init_done(init_done), .ref_req(ref_req), .ref_debt(ref_debt),
    .ref_ovf(ref_ovf), .cmd_own(cmd_own), .cmd_cke(cmd_cke),
    .cmd_cs_n(cmd_cs_n), .cmd_ras_n(cmd_ras_n), .cmd_cas_n(cmd_cas_n),
    .cmd_we_n(cmd_we_n), .cmd_addr(cmd_addr), .cmd_ba(cmd_ba)
  );

  always #5 sdram_clk = ~sdram_clk;

  function automatic logic [31:0] pack(input logic cke, input logic [3:0] cmd,
                                       input logic [12:0] addr, input logic done,
                                       input logic own, input logic req,
                                       input logic [3:0] debt, input logic ovf);
    return {4'b0000, cke, cmd, addr, 2'b00, done, own, req, debt, ovf};
  endfunction

  function automatic logic [31:0] idle_word(input logic req, input logic [3:0] debt,
                                            input logic ovf);
    return pack(1'b1, C_NOP, 13'd0, 1'b1, 1'b0, req, debt, ovf);
  endfunction

  function automatic logic [31:0] observed();
    return {4'b0000, cmd_cke, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_addr,
            cmd_ba, init_done, cmd_own, ref_req, ref_debt, ref_ovf};
  endfunction

  task automatic tick();
    @(posedge sdram_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Cycle 0 is the first cycle after the edge that samples reset low.
  task automatic run_init(input string tag);
    for (int c = 0; c <= 38; c++) begin
      logic [3:0]  cmd;
      logic [12:0] addr;
      tick();
      cmd  = C_NOP;
      addr = 13'd0;
      if (c == 20) begin
        cmd  = C_PRE;
        addr = 13'h0400;
      end else if (c == 22 || c == 29) begin
        cmd = C_REF;
      end else if (c == 36) begin
        cmd  = C_LMR;
        addr = 13'h033;
      end
      check(tag, observed(), pack(c >= 20, cmd, addr, c >= 38, c < 38, 1'b0, 4'd0, 1'b0));
    end
  endtask

  initial begin
    logic [31:0] rst_word;
    int refs;
    int guard;
    rst_word = pack(1'b0, C_DES, 13'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    repeat (3) tick();
    check("reset_state", observed(), rst_word);
    sdram_reset = 1'b0;
    cyc = -1;
    run_init("init");

    $display("[TB] single refresh");
    run_to(87);
    check("before_expiry", observed(), idle_word(1'b0, 4'd0, 1'b0));
    tick();
    check("first_expiry", observed(), idle_word(1'b0, 4'd1, 1'b0));
    tick();
    check("req_raise", observed(), idle_word(1'b1, 4'd1, 1'b0));
    ref_gnt = 1'b1;
    for (int c = 90; c <= 99; c++) begin
      logic [3:0]  cmd;
      logic [12:0] addr;
      logic        busy;
      tick();
      cmd  = (c == 90) ? C_PRE : (c == 92) ? C_REF : C_NOP;
      addr = (c == 90) ? 13'h0400 : 13'd0;
      busy = (c < 99);
      check("single_ref", observed(),
            pack(1'b1, cmd, addr, 1'b1, busy, busy, busy ? 4'd1 : 4'd0, 1'b0));
    end
    ref_gnt = 1'b0;

    $display("[TB] back-to-back refresh");
    run_to(237);
    check("debt_two", observed(), idle_word(1'b1, 4'd2, 1'b0));
    tick();
    check("debt_three", observed(), idle_word(1'b1, 4'd3, 1'b0));
    ref_gnt = 1'b1;
    for (int c = 239; c <= 262; c++) begin
      logic [3:0]  cmd;
      logic [12:0] addr;
      logic [3:0]  debt;
      logic        busy;
      tick();
      cmd  = (c == 239) ? C_PRE :
             (c == 241 || c == 248 || c == 255) ? C_REF : C_NOP;
      addr = (c == 239) ? 13'h0400 : 13'd0;
      debt = (c < 248) ? 4'd3 : (c < 255) ? 4'd2 : (c < 262) ? 4'd1 : 4'd0;
      busy = (c < 262);
      check("b2b_ref", observed(), pack(1'b1, cmd, addr, 1'b1, busy, busy, debt, 1'b0));
    end
    for (int c = 263; c <= 265; c++) begin
      tick();
      check("gnt_without_req", observed(), idle_word(1'b0, 4'd0, 1'b0));
    end
    ref_gnt = 1'b0;

    $display("[TB] saturation");
    run_to(637);
    check("sat_debt7", observed(), idle_word(1'b1, 4'd7, 1'b0));
    tick();
    check("sat_debt8", observed(), idle_word(1'b1, 4'd8, 1'b0));
    run_to(687);
    check("sat_before_ovf", observed(), idle_word(1'b1, 4'd8, 1'b0));
    tick();
    check("sat_ovf", observed(), idle_word(1'b1, 4'd8, 1'b1));
    ref_gnt = 1'b1;
    refs  = 0;
    guard = 0;
    do begin
      tick();
      guard++;
      if ({cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} == C_REF) refs++;
      if (cyc == 738)
        check("expiry_during_refresh", observed(),
              pack(1'b1, C_NOP, 13'd0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1));
    end while (ref_req && guard < 200);
    check("drain_end_cycle", cyc, 32'd754);
    check("drain_ref_count", refs, 32'd9);
    check("drain_end_state", observed(), idle_word(1'b0, 4'd0, 1'b1));
    ref_gnt = 1'b0;

    $display("[TB] reset mid-refresh");
    run_to(787);
    check("pre_reset_idle", observed(), idle_word(1'b0, 4'd0, 1'b1));
    tick();
    check("pre_reset_expiry", observed(), idle_word(1'b0, 4'd1, 1'b1));
    tick();
    check("pre_reset_req", observed(), idle_word(1'b1, 4'd1, 1'b1));
    ref_gnt = 1'b1;
    tick();
    check("pre_reset_pre", observed(),
          pack(1'b1, C_PRE, 13'h0400, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1));
    tick();
    check("pre_reset_trp", observed(),
          pack(1'b1, C_NOP, 13'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1));
    sdram_reset = 1'b1;
    tick();
    check("mid_refresh_reset", observed(), rst_word);
    ref_gnt = 1'b0;
    sdram_reset = 1'b0;
    cyc = -1;
    run_init("reinit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
